// File: rtl/dma_pkg.sv
// Shared definitions for the DMA peripheral port.
//   periph_state_t : handshake FSM states (IDLE -> REQ -> ACK -> STRB -> IDLE)
//   DMA_DATA_W     : default DMA data bus width
package dma_pkg;

  localparam int DMA_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    STRB = 2'd3
  } periph_state_t;

endpackage

// File: rtl/dma_periph_fifo.sv
// Synchronous FIFO holding the bytes that sit between the local device
// stream and the DMA bus.
//   clk, reset      : clock, synchronous active-high reset (flushes contents)
//   push, pushData  : write one entry; ignored when full
//   pop             : drop the head entry; ignored when empty
//   headData        : current head entry (valid when !empty)
//   full, empty     : occupancy flags
//   count           : number of stored entries, 0..DEPTH
module dma_periph_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        pushData,
  input  logic                     pop,
  output logic [DATA_W-1:0]        headData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wrPtr;
  logic [AW-1:0]     rdPtr;
  logic              doPush;
  logic              doPop;

  assign doPush   = push & ~full;
  assign doPop    = pop & ~empty;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign headData = mem[rdPtr];

  // Pointers are exactly AW bits wide, so DEPTH being a power of two makes
  // them wrap on their own; count carries the extra bit to tell full/empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/dma_periph_port.sv
// Peripheral end of an 8237A-style DMA channel handshake.
// Raises DREQ when the local FIFO has data for memory (dir=0) or room for
// data from memory (dir=1), answers one IOR/IOW strobe per request and
// treats EOP_N as terminal count.
//   CLK, RESET                : clock, synchronous active-high reset
//   enable, dir               : channel enable; transfer direction (0 dev->mem)
//   DREQ, DACK                : request out, acknowledge in (active level DACK_POL)
//   IOR_N, IOW_N, EOP_N       : active-low bus strobes and terminal count
//   DB_IN, DB_OUT, DB_OE      : data bus in, data bus out and its enable
//   in_valid/in_ready/in_data : local push stream (used when dir=0)
//   out_valid/out_ready/out_data : local pop stream (used when dir=1)
//   tc_done, ovf              : sticky terminal-count and overflow flags
//   dbgState, dbgCount        : FSM state and FIFO occupancy for observation
//
// Local streams use valid/ready: an entry moves on every CLK edge where both
// valid and ready are high; valid must not depend on ready, and data is
// held stable while valid is high and ready is low.
module dma_periph_port
  import dma_pkg::*;
#(
  parameter int DATA_W     = DMA_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter bit DACK_POL   = 1'b1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        enable,
  input  logic                        dir,
  output logic                        DREQ,
  input  logic                        DACK,
  input  logic                        IOR_N,
  input  logic                        IOW_N,
  input  logic                        EOP_N,
  input  logic [DATA_W-1:0]           DB_IN,
  output logic [DATA_W-1:0]           DB_OUT,
  output logic                        DB_OE,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        tc_done,
  output logic                        ovf,
  output periph_state_t               dbgState,
  output logic [$clog2(FIFO_DEPTH):0] dbgCount
);

  periph_state_t     state;
  periph_state_t     nextState;
  logic              iorQ;
  logic              iowQ;
  logic              dirQ;
  logic              eopSeen;
  logic              tcDone;
  logic              ovfQ;
  logic              dbOe;
  logic [DATA_W-1:0] dbOut;
  logic [DATA_W-1:0] dbInQ;

  logic              dackAct;
  logic              strbStart;
  logic              strbEnd;
  logic              eopNow;
  logic              busPush;
  logic              busPop;
  logic              setTc;
  logic              oeNext;

  logic              fifoPush;
  logic              fifoPop;
  logic [DATA_W-1:0] fifoPushData;
  logic [DATA_W-1:0] fifoHead;
  logic              fifoFull;
  logic              fifoEmpty;

  // Edges are taken between the previous sample (*Q) and the current one,
  // so a strobe change is acted on at the first CLK edge that sees it.
  assign dackAct   = (DACK == DACK_POL);
  assign strbStart = dirQ ? (iowQ & ~IOW_N) : (iorQ & ~IOR_N);
  assign strbEnd   = dirQ ? (~iowQ & IOW_N) : (~iorQ & IOR_N);
  assign eopNow    = eopSeen | ~EOP_N;

  always_comb begin
    nextState = state;
    busPush   = 1'b0;
    busPop    = 1'b0;
    setTc     = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !tcDone && (dirQ ? !fifoFull : !fifoEmpty))
          nextState = REQ;
      end
      // Once raised, DREQ is held until acknowledged, even if enable drops.
      REQ: begin
        if (dackAct) nextState = ACK;
      end
      ACK: begin
        if (strbStart) begin
          nextState = STRB;
        end else if (!dackAct) begin
          if (eopNow) begin
            setTc     = 1'b1;
            nextState = IDLE;
          end else begin
            nextState = REQ;
          end
        end
      end
      STRB: begin
        if (strbEnd) begin
          nextState = IDLE;
          setTc     = eopNow;
          busPush   = dirQ;
          busPop    = ~dirQ;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // The bus is driven only for cycles spent in STRB with IOR_N sampled low,
  // so DB_OE drops on the edge that sees IOR_N rise.
  assign oeNext = (nextState == STRB) && !dirQ && !IOR_N;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      iorQ    <= 1'b1;
      iowQ    <= 1'b1;
      dirQ    <= 1'b0;
      eopSeen <= 1'b0;
      tcDone  <= 1'b0;
      ovfQ    <= 1'b0;
      dbOe    <= 1'b0;
      dbOut   <= '0;
      dbInQ   <= '0;
    end else begin
      state <= nextState;
      iorQ  <= IOR_N;
      iowQ  <= IOW_N;
      // Direction may only change while nothing is buffered or requested.
      if (state == IDLE && nextState == IDLE && fifoEmpty && !fifoPush)
        dirQ <= dir;
      if (nextState == IDLE)
        eopSeen <= 1'b0;
      else if ((state == ACK || state == STRB) && !EOP_N)
        eopSeen <= 1'b1;
      if (setTc)
        tcDone <= 1'b1;
      else if (!enable)
        tcDone <= 1'b0;
      if (busPush && fifoFull)
        ovfQ <= 1'b1;
      dbOe  <= oeNext;
      dbOut <= oeNext ? fifoHead : '0;
      // Keep the last value seen while IOW_N is low; it is pushed on the rise.
      if (nextState == STRB && dirQ && !IOW_N)
        dbInQ <= DB_IN;
    end
  end

  assign fifoPush     = dirQ ? (busPush & ~fifoFull) : (in_valid & ~fifoFull);
  assign fifoPop      = dirQ ? (out_ready & ~fifoEmpty) : busPop;
  assign fifoPushData = dirQ ? dbInQ : in_data;

  dma_periph_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .reset    (RESET),
    .push     (fifoPush),
    .pushData (fifoPushData),
    .pop      (fifoPop),
    .headData (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (dbgCount)
  );

  assign DREQ      = (state != IDLE);
  assign DB_OE     = dbOe;
  assign DB_OUT    = dbOut;
  assign in_ready  = ~dirQ & ~fifoFull;
  assign out_valid = dirQ & ~fifoEmpty;
  assign out_data  = fifoHead;
  assign tc_done   = tcDone;
  assign ovf       = ovfQ;
  assign dbgState  = state;

endmodule
